// File: rtl/reg_status_file.sv
// Architectural register file with rename-tag tracking.
// Combinational reads with commit bypass; clocked commit, alloc and flush.
module reg_status_file #(
  parameter int DATA_LEN = 32,
  parameter int REG_NUM  = 32,
  parameter int REG_LEN  = 5,
  parameter int TAG_LEN  = 5,
  parameter int NUM_RD   = 2,
  parameter int CNT_LEN  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [NUM_RD*REG_LEN-1:0]    rs_addr,
  output logic [NUM_RD*DATA_LEN-1:0]   rs_val,
  output logic [NUM_RD*TAG_LEN-1:0]    rs_tag,
  input  logic                         alloc_en,
  input  logic [REG_LEN-1:0]           alloc_rd,
  input  logic [TAG_LEN-1:0]           alloc_tag,
  input  logic                         commit_en,
  input  logic [REG_LEN-1:0]           commit_rd,
  input  logic [TAG_LEN-1:0]           commit_tag,
  input  logic [DATA_LEN-1:0]          commit_val,
  input  logic                         flush,
  output logic [CNT_LEN-1:0]           pending_cnt
);

  logic [DATA_LEN-1:0] v [REG_NUM];
  logic [TAG_LEN-1:0]  q [REG_NUM];
  logic [CNT_LEN-1:0]  cnt;
  logic [CNT_LEN-1:0]  cnt_nxt;

  logic c_wr;
  logic a_wr;
  logic c_clr;
  logic same;
  logic inc;
  logic dec;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_LEN-1:0] a;
    logic               hit;

    assign a   = rs_addr[k*REG_LEN +: REG_LEN];
    assign hit = commit_en && (commit_rd == a) &&
                 (commit_tag == q[a]) && (q[a] != '0);

    assign rs_val[k*DATA_LEN +: DATA_LEN] =
      (a == '0) ? '0 : (hit ? commit_val : v[a]);
    assign rs_tag[k*TAG_LEN +: TAG_LEN] =
      ((a == '0) || hit) ? '0 : q[a];
  end

  assign c_wr  = commit_en && (commit_rd != '0);
  assign a_wr  = alloc_en && (alloc_rd != '0);
  assign c_clr = c_wr && (q[commit_rd] == commit_tag) &&
                 (q[commit_rd] != '0);
  assign same  = a_wr && c_wr && (alloc_rd == commit_rd);
  assign inc   = a_wr && (q[alloc_rd] == '0);
  // a clear overwritten by a same-cycle alloc leaves the reg pending
  assign dec   = c_clr && !same;

  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec)
      cnt_nxt = cnt + CNT_LEN'(1);
    else if (dec && !inc)
      cnt_nxt = cnt - CNT_LEN'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        v[i] <= '0;
        q[i] <= '0;
      end
      cnt <= '0;
    end else if (rdy) begin
      if (c_wr)
        v[commit_rd] <= commit_val;
      if (flush) begin
        for (int i = 0; i < REG_NUM; i++)
          q[i] <= '0;
        cnt <= '0;
      end else begin
        if (c_clr)
          q[commit_rd] <= '0;
        if (a_wr)
          q[alloc_rd] <= alloc_tag;
        cnt <= cnt_nxt;
      end
    end
  end

  assign pending_cnt = cnt;

endmodule

// File: tb/tb_reg_status_file.sv
// Directed vector bench for reg_status_file.
// Reads checked before each edge, pending_cnt after it.
module tb_reg_status_file;

  logic        clk = 0;
  logic        rst;
  logic        rdy;
  logic [9:0]  rs_addr;
  logic [63:0] rs_val;
  logic [9:0]  rs_tag;
  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic [4:0]  alloc_tag;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [4:0]  commit_tag;
  logic [31:0] commit_val;
  logic        flush;
  logic [5:0]  pending_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_status_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs_addr(rs_addr), .rs_val(rs_val), .rs_tag(rs_tag),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd),
    .alloc_tag(alloc_tag),
    .commit_en(commit_en), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_val(commit_val),
    .flush(flush), .pending_cnt(pending_cnt)
  );

  always @(posedge clk)
    if (!rst && rdy && alloc_en && !flush)
      assert (alloc_tag != 0)
        else $error("alloc_tag zero with alloc_en");

  typedef struct {
    logic        rst, rdy;
    logic        ae;
    logic [4:0]  ard, atag;
    logic        ce;
    logic [4:0]  crd, ctag;
    logic [31:0] cval;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic        chk;
    logic [31:0] ev0;
    logic [4:0]  et0;
    logic [31:0] ev1;
    logic [4:0]  et1;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vt [30];

  function automatic vec_t mk(
    logic r, logic y, logic ae, int ard, int atag,
    logic ce, int crd, int ctag, logic [31:0] cval,
    logic fl, int ra0, int ra1, logic chk,
    logic [31:0] ev0, int et0, logic [31:0] ev1, int et1,
    int ecnt);
    vec_t t;
    t.rst = r; t.rdy = y; t.ae = ae;
    t.ard = 5'(ard); t.atag = 5'(atag);
    t.ce = ce; t.crd = 5'(crd); t.ctag = 5'(ctag);
    t.cval = cval; t.fl = fl;
    t.ra0 = 5'(ra0); t.ra1 = 5'(ra1); t.chk = chk;
    t.ev0 = ev0; t.et0 = 5'(et0);
    t.ev1 = ev1; t.et1 = 5'(et1);
    t.ecnt = 6'(ecnt);
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst = t.rst; rdy = t.rdy;
    alloc_en = t.ae; alloc_rd = t.ard; alloc_tag = t.atag;
    commit_en = t.ce; commit_rd = t.crd;
    commit_tag = t.ctag; commit_val = t.cval;
    flush = t.fl; rs_addr = {t.ra1, t.ra0};
  endtask

  task automatic idle();
    rst = 0; rdy = 1; alloc_en = 0; alloc_rd = 0;
    alloc_tag = 0; commit_en = 0; commit_rd = 0;
    commit_tag = 0; commit_val = 0; flush = 0;
  endtask

  initial begin
    //          rst rdy ae ard at ce crd ct cval fl ra0 ra1 chk ev0 et0 ev1 et1 cnt
    vt[0]  = mk(1,0, 0,0,0,  0,0,0,0,            0, 5,31, 0, 0,0, 0,0, 0);
    vt[1]  = mk(1,1, 1,3,7,  0,0,0,0,            0, 5,31, 1, 0,0, 0,0, 0);
    vt[2]  = mk(0,1, 1,3,7,  0,0,0,0,            0, 3,5,  1, 0,0, 0,0, 1);
    vt[3]  = mk(0,1, 0,0,0,  0,0,0,0,            0, 3,0,  1, 0,7, 0,0, 1);
    vt[4]  = mk(0,1, 0,0,0,  1,3,7,32'hDEADBEEF, 0, 3,3,  1,
                32'hDEADBEEF,0, 32'hDEADBEEF,0, 0);
    vt[5]  = mk(0,1, 0,0,0,  0,0,0,0,            0, 3,0,  1,
                32'hDEADBEEF,0, 0,0, 0);
    vt[6]  = mk(0,1, 1,4,2,  0,0,0,0,            0, 4,0,  1, 0,0, 0,0, 1);
    vt[7]  = mk(0,1, 1,4,9,  0,0,0,0,            0, 4,0,  1, 0,2, 0,0, 1);
    vt[8]  = mk(0,1, 0,0,0,  1,4,2,32'h11,       0, 4,0,  1, 0,9, 0,0, 1);
    vt[9]  = mk(0,1, 0,0,0,  0,0,0,0,            0, 4,3,  1,
                32'h11,9, 32'hDEADBEEF,0, 1);
    vt[10] = mk(0,1, 1,6,3,  0,0,0,0,            0, 6,0,  1, 0,0, 0,0, 2);
    vt[11] = mk(0,1, 1,6,12, 1,6,3,32'h55,       0, 6,0,  1, 32'h55,0, 0,0, 2);
    vt[12] = mk(0,1, 0,0,0,  0,0,0,0,            0, 6,4,  1,
                32'h55,12, 32'h11,9, 2);
    vt[13] = mk(0,1, 1,1,1,  0,0,0,0,            0, 1,0,  1, 0,0, 0,0, 3);
    vt[14] = mk(0,1, 1,2,5,  0,0,0,0,            0, 1,0,  1, 0,1, 0,0, 4);
    vt[15] = mk(0,1, 1,10,8, 0,0,0,0,            0, 2,0,  1, 0,5, 0,0, 5);
    vt[16] = mk(0,1, 1,11,4, 1,2,5,32'h77,       1, 2,10, 1, 32'h77,0, 0,8, 0);
    vt[17] = mk(0,1, 0,0,0,  0,0,0,0,            0, 2,11, 1, 32'h77,0, 0,0, 0);
    vt[18] = mk(0,1, 0,0,0,  0,0,0,0,            0, 10,6, 1, 0,0, 32'h55,0, 0);
    vt[19] = mk(0,1, 1,0,3,  1,0,0,32'hFFFF,     0, 0,0,  1, 0,0, 0,0, 0);
    vt[20] = mk(0,1, 0,0,0,  0,0,0,0,            0, 0,2,  1, 0,0, 32'h77,0, 0);
    vt[21] = mk(0,0, 1,8,5,  1,2,0,32'h99,       0, 8,2,  1, 0,0, 32'h77,0, 0);
    vt[22] = mk(0,1, 0,0,0,  0,0,0,0,            0, 8,2,  1, 0,0, 32'h77,0, 0);
    vt[23] = mk(0,1, 1,9,6,  0,0,0,0,            0, 9,0,  1, 0,0, 0,0, 1);
    vt[24] = mk(0,0, 0,0,0,  1,9,6,32'h42,       1, 9,0,  1, 32'h42,0, 0,0, 1);
    vt[25] = mk(0,1, 0,0,0,  0,0,0,0,            0, 9,0,  1, 0,6, 0,0, 1);
    vt[26] = mk(0,1, 0,0,0,  1,5,0,32'h123,      0, 5,0,  1, 0,0, 0,0, 1);
    vt[27] = mk(0,1, 0,0,0,  0,0,0,0,            0, 5,9,  1, 32'h123,0, 0,6, 1);
    vt[28] = mk(1,0, 1,7,3,  0,0,0,0,            0, 9,3,  1, 0,6, 32'hDEADBEEF,0, 0);
    vt[29] = mk(0,1, 0,0,0,  0,0,0,0,            0, 9,3,  1, 0,0, 0,0, 0);

    idle();
    rs_addr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      if (vt[i].chk) begin
        check($sformatf("v%0d val0", i), rs_val[31:0], vt[i].ev0);
        check($sformatf("v%0d tag0", i), 32'(rs_tag[4:0]), 32'(vt[i].et0));
        check($sformatf("v%0d val1", i), rs_val[63:32], vt[i].ev1);
        check($sformatf("v%0d tag1", i), 32'(rs_tag[9:5]), 32'(vt[i].et1));
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d cnt", i), 32'(pending_cnt), 32'(vt[i].ecnt));
    end

    // fill every register to reach the count ceiling
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      idle();
      alloc_en = 1; alloc_rd = 5'(r); alloc_tag = 5'(r);
      @(posedge clk);
      #1;
      if (r == 1 || r == 16 || r == 31)
        check($sformatf("fill cnt r%0d", r), 32'(pending_cnt), r);
    end
    @(negedge clk);
    idle();
    alloc_en = 1; alloc_rd = 5; alloc_tag = 2;
    rs_addr = {5'd17, 5'd31};
    #1;
    check("full tag31", 32'(rs_tag[4:0]), 31);
    check("full tag17", 32'(rs_tag[9:5]), 17);
    @(posedge clk);
    #1;
    check("realloc cnt", 32'(pending_cnt), 31);
    @(negedge clk);
    idle();
    commit_en = 1; commit_rd = 31; commit_tag = 31;
    commit_val = 32'hA5;
    @(posedge clk);
    #1;
    check("commit from full", 32'(pending_cnt), 30);
    @(negedge clk);
    idle();
    flush = 1;
    @(posedge clk);
    #1;
    check("flush full", 32'(pending_cnt), 0);
    @(negedge clk);
    idle();
    rs_addr = {5'd5, 5'd31};
    #1;
    check("post val31", rs_val[31:0], 32'hA5);
    check("post tag5", 32'(rs_tag[9:5]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
